// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder column per clock, a single carry flop links the columns.
// Latency: done pulses WIDTH cycles after the accepted start edge; throughput is one add per WIDTH+2 cycles.
// Backpressure: none; start is honoured only in IDLE and dropped (not queued) while RUN or DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full adder built from two half adders; their carries can never both be set, so OR merges them.
    assign ha1_s     = a_sr[0] ^ b_sr[0];
    assign ha1_c     = a_sr[0] & b_sr[0];
    assign ha2_s     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;
    assign res_nxt   = {ha2_s, res_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            c_out  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt[WIDTH-1:1];
                    carry  <= carry_nxt;
                    cnt    <= cnt + 1'b1;
                    // Last column goes straight into sum so partial results never appear on the port.
                    if (cnt == LAST) begin
                        sum   <= res_nxt;
                        c_out <= carry_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
